time_scheduler: RTL

- Central emulation-time scheduler for a bank of N emulated clock generators (TX/RX clocks, each with a time_eq/cke interface).
- Scans each generator's next-edge time, selects the earliest, and broadcasts it as the shared time_next.
- All clocks compare against the same time_next, so exactly the due clock(s) fire each emulation step.
- Sits at top level between the clock instances and the channel/datapath time bus.

---
 rtl/time_scheduler_if.sv | 37 +++
 rtl/time_scheduler.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/time_scheduler_if.sv
// Time bus between the emulated clock bank (master) and the time scheduler (slave).
// step_clamped exists only when TIME_SCHED_MAX_STEP_EN is defined.
interface time_scheduler_if #(
  parameter int unsigned N          = 4,
  parameter int unsigned TIME_WIDTH = 32,
  parameter int unsigned IDX_WIDTH  = 4
);
  logic                    run;
  logic [N*TIME_WIDTH-1:0] time_clock_in;
  logic [TIME_WIDTH-1:0]   time_next;
  logic                    time_valid;
  logic [IDX_WIDTH-1:0]    winner_idx;
  logic [31:0]             step_count;
  logic                    busy;
  logic                    err_backstep;
`ifdef TIME_SCHED_MAX_STEP_EN
  logic                    step_clamped;

  modport master (
    output run, time_clock_in,
    input  time_next, time_valid, winner_idx, step_count, busy, err_backstep, step_clamped
  );
  modport slave (
    input  run, time_clock_in,
    output time_next, time_valid, winner_idx, step_count, busy, err_backstep, step_clamped
  );
`else
  modport master (
    output run, time_clock_in,
    input  time_next, time_valid, winner_idx, step_count, busy, err_backstep
  );
  modport slave (
    input  run, time_clock_in,
    output time_next, time_valid, winner_idx, step_count, busy, err_backstep
  );
`endif
endinterface

// File: rtl/time_scheduler.sv
// Emulation-time scheduler: scans N next-edge times one per cycle and issues the minimum as time_next.
// Optional per-step advance limit enabled by defining TIME_SCHED_MAX_STEP_EN.
module time_scheduler #(
  parameter int unsigned N          = 4,
  parameter int unsigned TIME_WIDTH = 32,
  parameter int unsigned IDX_WIDTH  = 4,
  parameter int unsigned MAX_STEP   = 1024
) (
  input  logic               clk,
  input  logic               rst,
  time_scheduler_if.slave    bus
);

  if (N < 1 || N > 16 || (2**IDX_WIDTH) < N || MAX_STEP == 0) begin : g_bad_params
    $error("time_scheduler: illegal parameter combination");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    ISSUE = 2'd2
  } state_t;

  state_t                state, state_next;
  logic [IDX_WIDTH-1:0]  idx;
  logic [TIME_WIDTH-1:0] best;
  logic [IDX_WIDTH-1:0]  best_idx;
  logic [TIME_WIDTH-1:0] time_next_q;
  logic [IDX_WIDTH-1:0]  winner_idx_q;
  logic [31:0]           step_count_q;
  logic                  time_valid_q;
  logic                  err_backstep_q;
  logic [TIME_WIDTH-1:0] cur;
  logic                  scan_last;
  logic                  backstep;

  always_comb begin
    cur = '1;
    for (int unsigned i = 0; i < N; i++) begin
      if (idx == IDX_WIDTH'(i)) cur = bus.time_clock_in[i*TIME_WIDTH +: TIME_WIDTH];
    end
  end

  assign scan_last = (idx == IDX_WIDTH'(N - 1));
  assign backstep  = (best < time_next_q);

`ifdef TIME_SCHED_MAX_STEP_EN
  logic [TIME_WIDTH:0]   limit_wide;
  logic [TIME_WIDTH-1:0] limit;
  logic                  clamp;
  logic                  step_clamped_q;

  assign limit_wide = {1'b0, time_next_q} + (TIME_WIDTH+1)'(MAX_STEP);
  assign limit      = limit_wide[TIME_WIDTH] ? '1 : limit_wide[TIME_WIDTH-1:0];
  assign clamp      = (best > limit);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (bus.run) state_next = SCAN;
      SCAN:    if (scan_last) state_next = ISSUE;
      ISSUE:   state_next = bus.run ? SCAN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx            <= '0;
      best           <= '1;
      best_idx       <= '0;
      time_next_q    <= '0;
      winner_idx_q   <= '0;
      step_count_q   <= '0;
      time_valid_q   <= 1'b0;
      err_backstep_q <= 1'b0;
`ifdef TIME_SCHED_MAX_STEP_EN
      step_clamped_q <= 1'b0;
`endif
    end else begin
      time_valid_q <= 1'b0;
`ifdef TIME_SCHED_MAX_STEP_EN
      step_clamped_q <= 1'b0;
`endif
      unique case (state)
        IDLE: begin
          idx      <= '0;
          best     <= '1;
          best_idx <= '0;
        end
        SCAN: begin
          // strict compare in ascending index order keeps the lower index on ties
          if (cur < best) begin
            best     <= cur;
            best_idx <= idx;
          end
          idx <= scan_last ? '0 : idx + 1'b1;
        end
        ISSUE: begin
          time_valid_q <= 1'b1;
          if (backstep) begin
            err_backstep_q <= 1'b1;
          end else begin
            step_count_q <= step_count_q + 32'd1;
`ifdef TIME_SCHED_MAX_STEP_EN
            if (clamp) begin
              time_next_q    <= limit;
              step_clamped_q <= 1'b1;
            end else begin
              time_next_q  <= best;
              winner_idx_q <= best_idx;
            end
`else
            time_next_q  <= best;
            winner_idx_q <= best_idx;
`endif
          end
          idx      <= '0;
          best     <= '1;
          best_idx <= '0;
        end
        default: ;
      endcase
    end
  end

  assign bus.time_next    = time_next_q;
  assign bus.time_valid   = time_valid_q;
  assign bus.winner_idx   = winner_idx_q;
  assign bus.step_count   = step_count_q;
  assign bus.busy         = (state != IDLE);
  assign bus.err_backstep = err_backstep_q;
`ifdef TIME_SCHED_MAX_STEP_EN
  assign bus.step_clamped = step_clamped_q;
`endif

endmodule
